// File: rtl/seg_pkg.sv
// seg_pkg: shared types and helpers for the seven-segment scan driver.
//   apply_pol  - applies pin polarity to a logical (1 = active) word
//   onehot     - logical one-hot enable word for a digit index
//   SEG_BLANK  - logical all-off glyph
package seg_pkg;

  // Widest word the helpers handle; callers zero-extend into it and slice back.
  localparam int MAX_W = 32;

  localparam logic [MAX_W-1:0] SEG_BLANK = {MAX_W{1'b0}};

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_DARK = 1'b1
  } run_state_t;

  function automatic logic [MAX_W-1:0] apply_pol(input logic [MAX_W-1:0] value,
                                                 input logic             active_low);
    logic [MAX_W-1:0] result;
    if (active_low) begin
      result = ~value;
    end else begin
      result = value;
    end
    return result;
  endfunction

  function automatic logic [MAX_W-1:0] onehot(input logic [4:0] idx, input int n);
    logic [MAX_W-1:0] result;
    result = {MAX_W{1'b0}};
    if (int'(idx) < n) begin
      result[idx] = 1'b1;
    end else begin
      result = {MAX_W{1'b0}};
    end
    return result;
  endfunction

endpackage

// File: rtl/seg_slot_timer.sv
// seg_slot_timer: slot and digit counters for the scan driver.
//   clk_fast, rst  - scan clock, async active-high reset
//   brightness     - PWM on-time minus one
//   sub_cnt        - cycle within the current slot
//   digit_idx      - digit currently being scanned
//   slot_end       - last cycle of a slot
//   frame_end      - last cycle of the slot of the last digit
//   frame_first    - first cycle of digit 0's slot
//   pwm_on         - current cycle lies inside the PWM on-window
module seg_slot_timer #(
  parameter int DIGITS   = 8,
  parameter int PWM_BITS = 2,
  parameter int IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
  input  logic                clk_fast,
  input  logic                rst,
  input  logic [PWM_BITS-1:0] brightness,
  output logic [PWM_BITS-1:0] sub_cnt,
  output logic [IDX_W-1:0]    digit_idx,
  output logic                slot_end,
  output logic                frame_end,
  output logic                frame_first,
  output logic                pwm_on
);

  localparam logic [PWM_BITS-1:0] SUB_LAST = {PWM_BITS{1'b1}};
  localparam logic [IDX_W-1:0]    IDX_LAST = IDX_W'(DIGITS - 1);

  assign slot_end    = (sub_cnt == SUB_LAST);
  assign frame_end   = slot_end && (digit_idx == IDX_LAST);
  assign frame_first = (sub_cnt == {PWM_BITS{1'b0}}) && (digit_idx == {IDX_W{1'b0}});
  assign pwm_on      = (sub_cnt <= brightness);

  // Free-running slot/digit counters; they keep scanning even while dark.
  always_ff @(posedge clk_fast or posedge rst) begin
    if (rst) begin
      sub_cnt   <= {PWM_BITS{1'b0}};
      digit_idx <= {IDX_W{1'b0}};
    end else begin
      sub_cnt <= sub_cnt + PWM_BITS'(1);
      if (slot_end) begin
        if (digit_idx == IDX_LAST) begin
          digit_idx <= {IDX_W{1'b0}};
        end else begin
          digit_idx <= digit_idx + IDX_W'(1);
        end
      end else begin
        digit_idx <= digit_idx;
      end
    end
  end

endmodule

// File: rtl/seg_scan_mux.sv
// seg_scan_mux: time-multiplexed seven-segment driver with PWM brightness,
// per-digit blink and a double-buffered frame that swaps only at frame ends.
//   clk_fast, rst  - scan clock, async active-high reset
//   frame_in/load  - new frame and its capture strobe
//   brightness     - PWM on-time minus one
//   blink_mask     - digits that blink; blink_tick toggles the blink phase
//   enable         - display on/off, applied at slot boundaries
//   seg_en/seg_out - registered digit enables and segment drive (pin polarity)
//   frame_start    - pulse on digit 0's first output cycle
//   pending        - a loaded frame is waiting for the next frame boundary
module seg_scan_mux
  import seg_pkg::*;
#(
  parameter int DIGITS         = 8,
  parameter int SEG_W          = 8,
  parameter int PWM_BITS       = 2,
  parameter bit EN_ACTIVE_LOW  = 1'b1,
  parameter bit SEG_ACTIVE_LOW = 1'b0
) (
  input  logic                    clk_fast,
  input  logic                    rst,
  input  logic [DIGITS*SEG_W-1:0] frame_in,
  input  logic                    load,
  input  logic [PWM_BITS-1:0]     brightness,
  input  logic [DIGITS-1:0]       blink_mask,
  input  logic                    blink_tick,
  input  logic                    enable,
  output logic [DIGITS-1:0]       seg_en,
  output logic [SEG_W-1:0]        seg_out,
  output logic                    frame_start,
  output logic                    pending
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [MAX_W-1:0]  EN_IDLE_W  = apply_pol(SEG_BLANK, EN_ACTIVE_LOW);
  localparam logic [MAX_W-1:0]  SEG_IDLE_W = apply_pol(SEG_BLANK, SEG_ACTIVE_LOW);
  localparam logic [DIGITS-1:0] EN_IDLE    = EN_IDLE_W[DIGITS-1:0];
  localparam logic [SEG_W-1:0]  SEG_IDLE   = SEG_IDLE_W[SEG_W-1:0];

  logic [DIGITS-1:0][SEG_W-1:0] active;
  logic [DIGITS-1:0][SEG_W-1:0] pending_buf;
  run_state_t                   state;
  logic                         blink_phase;

  logic [PWM_BITS-1:0] sub_cnt;
  logic [IDX_W-1:0]    digit_idx;
  logic                slot_end;
  logic                frame_end;
  logic                frame_first;
  logic                pwm_on;

  logic                lit;
  logic [SEG_W-1:0]    glyph;
  logic [MAX_W-1:0]    en_word;
  logic [MAX_W-1:0]    seg_word;

  seg_slot_timer #(
    .DIGITS   (DIGITS),
    .PWM_BITS (PWM_BITS),
    .IDX_W    (IDX_W)
  ) u_timer (
    .clk_fast    (clk_fast),
    .rst         (rst),
    .brightness  (brightness),
    .sub_cnt     (sub_cnt),
    .digit_idx   (digit_idx),
    .slot_end    (slot_end),
    .frame_end   (frame_end),
    .frame_first (frame_first),
    .pwm_on      (pwm_on)
  );

  // Next-cycle drive for the current digit, converted to pin polarity.
  always_comb begin
    glyph    = active[digit_idx];
    lit      = (state == ST_RUN) && pwm_on && !(blink_mask[digit_idx] && blink_phase);
    en_word  = EN_IDLE_W;
    seg_word = SEG_IDLE_W;
    if (lit) begin
      en_word  = apply_pol(onehot({{(5-IDX_W){1'b0}}, digit_idx}, DIGITS), EN_ACTIVE_LOW);
      seg_word = apply_pol({{(MAX_W-SEG_W){1'b0}}, glyph}, SEG_ACTIVE_LOW);
    end else begin
      en_word  = EN_IDLE_W;
      seg_word = SEG_IDLE_W;
    end
  end

  // Double buffer: a load on the frame-end cycle bypasses straight into active.
  always_ff @(posedge clk_fast or posedge rst) begin
    if (rst) begin
      active      <= {(DIGITS*SEG_W){1'b0}};
      pending_buf <= {(DIGITS*SEG_W){1'b0}};
      pending     <= 1'b0;
    end else if (load) begin
      pending_buf <= frame_in;
      if (frame_end) begin
        active  <= frame_in;
        pending <= 1'b0;
      end else begin
        pending <= 1'b1;
      end
    end else if (frame_end && pending) begin
      active  <= pending_buf;
      pending <= 1'b0;
    end else begin
      pending <= pending;
    end
  end

  // RUN/DARK state machine, evaluated only at slot boundaries so a slot is never cut short.
  always_ff @(posedge clk_fast or posedge rst) begin
    if (rst) begin
      state <= ST_RUN;
    end else if (slot_end) begin
      case (state)
        ST_RUN:  state <= enable ? ST_RUN : ST_DARK;
        ST_DARK: state <= enable ? ST_RUN : ST_DARK;
        default: state <= ST_RUN;
      endcase
    end else begin
      state <= state;
    end
  end

  // Blink phase; forced visible while no digit is selected for blinking.
  always_ff @(posedge clk_fast or posedge rst) begin
    if (rst) begin
      blink_phase <= 1'b0;
    end else if (blink_mask == {DIGITS{1'b0}}) begin
      blink_phase <= 1'b0;
    end else begin
      blink_phase <= blink_phase ^ blink_tick;
    end
  end

  // Output registers: enables and segments change on the same edge.
  always_ff @(posedge clk_fast or posedge rst) begin
    if (rst) begin
      seg_en      <= EN_IDLE;
      seg_out     <= SEG_IDLE;
      frame_start <= 1'b0;
    end else begin
      seg_en      <= en_word[DIGITS-1:0];
      seg_out     <= seg_word[SEG_W-1:0];
      frame_start <= frame_first;
    end
  end

endmodule

// File: tb/tb_seg_scan_mux.sv
// Self-checking bench for seg_scan_mux (DIGITS=8, PWM_BITS=2, enables active-low).
// A behavioural model indexed by the cycle position since reset predicts
// the registered outputs one cycle ahead.
module tb_seg_scan_mux;

  logic        clk_fast;
  logic        rst;
  logic [63:0] frame_in;
  logic        load;
  logic [1:0]  brightness;
  logic [7:0]  blink_mask;
  logic        blink_tick;
  logic        enable;
  logic [7:0]  seg_en;
  logic [7:0]  seg_out;
  logic        frame_start;
  logic        pending;

  int total;
  int bad;

  // Model state
  int          pos;
  logic [7:0]  m_active [8];
  logic [63:0] m_buf;
  logic        m_pending;
  logic        m_run;
  logic        m_phase;
  logic [17:0] exp_vec;

  seg_scan_mux dut (
    .clk_fast    (clk_fast),
    .rst         (rst),
    .frame_in    (frame_in),
    .load        (load),
    .brightness  (brightness),
    .blink_mask  (blink_mask),
    .blink_tick  (blink_tick),
    .enable      (enable),
    .seg_en      (seg_en),
    .seg_out     (seg_out),
    .frame_start (frame_start),
    .pending     (pending)
  );

  initial begin
    clk_fast = 1'b0;
    forever #5 clk_fast = ~clk_fast;
  end

  task automatic model_reset();
    pos       = 0;
    for (int k = 0; k < 8; k++) m_active[k] = 8'h00;
    m_buf     = 64'h0;
    m_pending = 1'b0;
    m_run     = 1'b1;
    m_phase   = 1'b0;
  endtask

  // Predict the outputs produced by the next edge, update the model, advance one cycle.
  task automatic step();
    int         d;
    int         s;
    logic       fe;
    logic       lit;
    logic [7:0] en_exp;
    logic [7:0] one;
    d   = (pos / 4) % 8;
    s   = pos % 4;
    fe  = ((pos % 32) == 31);
    lit = m_run && (s <= int'(brightness)) && !(blink_mask[d] && m_phase);
    one = 8'h01 << d;
    en_exp = lit ? ~one : 8'hFF;
    exp_vec = {en_exp, (lit ? m_active[d] : 8'h00), ((pos % 32) == 0), 1'b0};
    if (load) begin
      if (fe) begin
        for (int k = 0; k < 8; k++) m_active[k] = frame_in[k*8 +: 8];
        m_pending = 1'b0;
      end else begin
        m_buf     = frame_in;
        m_pending = 1'b1;
      end
    end else if (fe && m_pending) begin
      for (int k = 0; k < 8; k++) m_active[k] = m_buf[k*8 +: 8];
      m_pending = 1'b0;
    end
    exp_vec[0] = m_pending;
    if (s == 3) m_run = enable;
    if (blink_mask == 8'h00) m_phase = 1'b0;
    else m_phase = m_phase ^ blink_tick;
    pos++;
    @(posedge clk_fast);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #23;
    if ({seg_en, seg_out, frame_start, pending} !== 18'h3FC00) begin
      bad++;
      $display("FAIL reset_state got=%h want=%h", {seg_en, seg_out, frame_start, pending}, 18'h3FC00);
    end
    total++;
    rst = 1'b0;
    model_reset();
    step();
    if (frame_start !== 1'b1) begin
      bad++;
      $display("FAIL reset_first_frame_start got=%b want=1", frame_start);
    end
    total++;
  endtask

  task automatic test_frame();
    logic [7:0] one;
    frame_in = 64'h0706050403020100;
    load = 1'b1;
    step();
    load = 1'b0;
    for (int i = 0; i < 40 && (pos % 32) != 1; i++) step();
    for (int i = 0; i < 32; i++) begin
      one = 8'h01 << (i / 4);
      if (seg_out !== 8'(i / 4) || seg_en !== ~one) begin
        bad++;
        $display("FAIL frame_digit i=%0d got=%h/%h want=%h/%h", i, seg_en, seg_out, ~one, 8'(i / 4));
      end
      total++;
      if ({seg_en, seg_out, frame_start, pending} !== exp_vec) begin
        bad++;
        $display("FAIL frame_model pos=%0d got=%h want=%h", pos, {seg_en, seg_out, frame_start, pending}, exp_vec);
      end
      total++;
      step();
    end
  endtask

  task automatic test_dim();
    int on_cycles;
    brightness = 2'd0;
    for (int i = 0; i < 40 && (pos % 32) != 0; i++) step();
    on_cycles = 0;
    for (int i = 0; i < 32; i++) begin
      step();
      if (seg_en !== 8'hFF) on_cycles++;
      if ({seg_en, seg_out, frame_start, pending} !== exp_vec) begin
        bad++;
        $display("FAIL dim pos=%0d got=%h want=%h", pos, {seg_en, seg_out, frame_start, pending}, exp_vec);
      end
      total++;
    end
    if (on_cycles != 8) begin
      bad++;
      $display("FAIL dim_on_cycles got=%0d want=8", on_cycles);
    end
    total++;
    brightness = 2'd3;
  endtask

  task automatic test_pending();
    for (int i = 0; i < 40 && (pos % 32) != 12; i++) step();
    frame_in = {$urandom, $urandom};
    load = 1'b1;
    step();
    load = 1'b0;
    if (pending !== 1'b1) begin
      bad++;
      $display("FAIL pending_set got=%b want=1", pending);
    end
    total++;
    for (int i = 0; i < 40; i++) begin
      step();
      if ({seg_en, seg_out, frame_start, pending} !== exp_vec) begin
        bad++;
        $display("FAIL pending pos=%0d got=%h want=%h", pos, {seg_en, seg_out, frame_start, pending}, exp_vec);
      end
      total++;
    end
  endtask

  task automatic test_boundary_load();
    for (int i = 0; i < 40 && (pos % 32) != 31; i++) step();
    frame_in = {$urandom, $urandom};
    load = 1'b1;
    step();
    load = 1'b0;
    if (pending !== 1'b0) begin
      bad++;
      $display("FAIL boundary_pending got=%b want=0", pending);
    end
    total++;
    for (int i = 0; i < 34; i++) begin
      step();
      if ({seg_en, seg_out, frame_start, pending} !== exp_vec) begin
        bad++;
        $display("FAIL boundary pos=%0d got=%h want=%h", pos, {seg_en, seg_out, frame_start, pending}, exp_vec);
      end
      total++;
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 40 && (pos % 32) != 5; i++) step();
    load = 1'b1;
    frame_in = {$urandom, $urandom};
    step();
    frame_in = {$urandom, $urandom};
    step();
    load = 1'b0;
    for (int i = 0; i < 60; i++) begin
      step();
      if ({seg_en, seg_out, frame_start, pending} !== exp_vec) begin
        bad++;
        $display("FAIL back_to_back pos=%0d got=%h want=%h", pos, {seg_en, seg_out, frame_start, pending}, exp_vec);
      end
      total++;
    end
  endtask

  task automatic test_blink();
    blink_mask = 8'h04;
    step();
    for (int t = 0; t < 2; t++) begin
      blink_tick = 1'b1;
      step();
      blink_tick = 1'b0;
      for (int i = 0; i < 40; i++) begin
        step();
        if ({seg_en, seg_out, frame_start, pending} !== exp_vec) begin
          bad++;
          $display("FAIL blink tick=%0d pos=%0d got=%h want=%h", t, pos, {seg_en, seg_out, frame_start, pending}, exp_vec);
        end
        total++;
      end
    end
    blink_mask = 8'h00;
  endtask

  task automatic test_enable();
    for (int i = 0; i < 40 && (pos % 32) != 22; i++) step();
    enable = 1'b0;
    for (int i = 0; i < 50; i++) begin
      step();
      if ({seg_en, seg_out, frame_start, pending} !== exp_vec) begin
        bad++;
        $display("FAIL enable_off pos=%0d got=%h want=%h", pos, {seg_en, seg_out, frame_start, pending}, exp_vec);
      end
      total++;
      if ((pos % 32) == 10) enable = 1'b1;
    end
    enable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      if ({seg_en, seg_out, frame_start, pending} !== exp_vec) begin
        bad++;
        $display("FAIL enable_on pos=%0d got=%h want=%h", pos, {seg_en, seg_out, frame_start, pending}, exp_vec);
      end
      total++;
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 40 && (pos % 32) != 9; i++) step();
    frame_in = {$urandom, $urandom};
    load = 1'b1;
    step();
    load = 1'b0;
    step();
    rst = 1'b1;
    #1;
    if ({seg_en, seg_out, pending} !== 17'h1FE00) begin
      bad++;
      $display("FAIL reset_mid_outputs got=%h want=%h", {seg_en, seg_out, pending}, 17'h1FE00);
    end
    total++;
    @(posedge clk_fast);
    #3;
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 33; i++) begin
      step();
      if ({seg_en, seg_out, frame_start, pending} !== exp_vec) begin
        bad++;
        $display("FAIL reset_mid pos=%0d got=%h want=%h", pos, {seg_en, seg_out, frame_start, pending}, exp_vec);
      end
      total++;
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      load       = ($urandom_range(7) == 0);
      frame_in   = {$urandom, $urandom};
      blink_tick = ($urandom_range(15) == 0);
      enable     = ($urandom_range(9) != 0);
      if ($urandom_range(31) == 0) brightness = 2'($urandom_range(3));
      if ($urandom_range(63) == 0) blink_mask = 8'($urandom_range(255));
      step();
      if ({seg_en, seg_out, frame_start, pending} !== exp_vec) begin
        bad++;
        $display("FAIL random pos=%0d got=%h want=%h", pos, {seg_en, seg_out, frame_start, pending}, exp_vec);
      end
      total++;
    end
    load = 1'b0;
    blink_tick = 1'b0;
    enable = 1'b1;
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    frame_in   = 64'h0;
    load       = 1'b0;
    brightness = 2'd3;
    blink_mask = 8'h00;
    blink_tick = 1'b0;
    enable     = 1'b1;
    model_reset();
    test_reset();
    test_frame();
    test_dim();
    test_pending();
    test_boundary_load();
    test_back_to_back();
    test_blink();
    test_enable();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
